nn_job_arbiter: RTL and testbench



---
 rtl/nn_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/nn_job_arbiter.sv | 148 ++++++++++++++
 tb/tb_nn_job_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_sched_pkg.sv
// Shared types and constants for the inference-engine job scheduler.
// Also holds the round-robin pointer helper used by the arbiter top level.
package nn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

  localparam int CLASS_W = 4;
  localparam logic [CLASS_W-1:0] CLASS_TIMEOUT = 4'hF;

  // The requester after the one just served gets first look next time.
  function automatic int rr_next(input int id, input int n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above ptr_i, wrapping.
// It produces a one-hot grant, the granted index and an any flag.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand;
      end
    end
  end

endmodule

// File: rtl/nn_job_arbiter.sv
// Round-robin job sequencer that shares one MNIST inference engine between several requesters,
// with a watchdog on the engine's done and a tagged valid/ready response channel.
module nn_job_arbiter
  import nn_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int IMG_W          = 2,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*IMG_W-1:0] req_img_sel,
  output logic                     nn_start,
  output logic [IMG_W-1:0]         nn_img_sel,
  output logic                     nn_flush,
  input  logic                     nn_done,
  input  logic [CLASS_W-1:0]       nn_class,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CLASS_W-1:0]       rsp_class,
  output logic                     rsp_timeout,
  output logic                     busy
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [IMG_W-1:0]     img_q, img_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [CLASS_W-1:0]   rsp_class_q, rsp_class_d;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic                 wdog_expired;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign wdog_expired = (wdog_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      img_q         <= '0;
      wdog_q        <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_class_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      img_q         <= img_d;
      wdog_q        <= wdog_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_class_q   <= rsp_class_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (nn_done || wdog_expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // nn_flush is decoded from registered state so it lands in the very cycle the abort is decided.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    img_d         = img_q;
    wdog_d        = wdog_q;
    rsp_class_d   = rsp_class_q;
    rsp_timeout_d = rsp_timeout_q;
    start_d       = 1'b0;
    req_ready     = '0;
    nn_flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) req_ready = grant;
        if (grant_any) begin
          id_d    = grant_idx;
          start_d = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) img_d = req_img_sel[i*IMG_W +: IMG_W];
          end
        end
      end
      START: wdog_d = '0;
      WAIT: begin
        if (nn_done) begin
          rsp_class_d   = nn_class;
          rsp_timeout_d = 1'b0;
        end else if (wdog_expired) begin
          rsp_class_d   = CLASS_TIMEOUT;
          rsp_timeout_d = 1'b1;
          nn_flush      = 1'b1;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      RESP: if (rsp_ready) rr_ptr_d = ID_W'(rr_next(int'(id_q), NUM_REQ));
      default: ;
    endcase
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  assign nn_start    = start_q;
  assign nn_img_sel  = img_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_class   = rsp_class_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nn_job_arbiter.sv
// Self-checking bench for nn_job_arbiter: table-driven jobs, hand-written corner sequences
// and randomized jobs checked against a job-level model of grant order, latency and timeout.
module tb_nn_job_arbiter;

  localparam int NREQ    = 2;
  localparam int IMGW    = 2;
  localparam int T_LONG  = 2000;
  localparam int T_SHORT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] reqValid = '0;
  logic [3:0] reqImgSel = '0;
  logic       nnDone = 1'b0;
  logic [3:0] nnClass = '0;
  logic       rspReady = 1'b0;

  logic [1:0] aReqReady, bReqReady;
  logic       aStart, bStart, aFlush, bFlush, aRspValid, bRspValid;
  logic       aRspId, bRspId, aTo, bTo, aBusy, bBusy;
  logic [1:0] aImg, bImg;
  logic [3:0] aCls, bCls;

  bit         useT = 1'b0;
  logic [1:0] obsReqReady, obsImg;
  logic       obsStart, obsFlush, obsRspValid, obsRspId, obsTo, obsBusy;
  logic [3:0] obsCls;

  int tests = 0;
  int fails = 0;
  int ptr = 0;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] imgs;
    int         doneDly;
    logic [3:0] cls;
    int         rdyDly;
    int         expId;
    logic [1:0] expImg;
    logic [3:0] expCls;
    logic       expTo;
  } vec_t;

  vec_t vecs[5];

  nn_job_arbiter #(.NUM_REQ(NREQ), .IMG_W(IMGW), .TIMEOUT_CYCLES(T_LONG)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(aReqReady),
    .req_img_sel(reqImgSel), .nn_start(aStart), .nn_img_sel(aImg), .nn_flush(aFlush),
    .nn_done(nnDone), .nn_class(nnClass), .rsp_valid(aRspValid), .rsp_ready(rspReady),
    .rsp_id(aRspId), .rsp_class(aCls), .rsp_timeout(aTo), .busy(aBusy)
  );

  nn_job_arbiter #(.NUM_REQ(NREQ), .IMG_W(IMGW), .TIMEOUT_CYCLES(T_SHORT)) dutT (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(bReqReady),
    .req_img_sel(reqImgSel), .nn_start(bStart), .nn_img_sel(bImg), .nn_flush(bFlush),
    .nn_done(nnDone), .nn_class(nnClass), .rsp_valid(bRspValid), .rsp_ready(rspReady),
    .rsp_id(bRspId), .rsp_class(bCls), .rsp_timeout(bTo), .busy(bBusy)
  );

  assign obsReqReady = useT ? bReqReady : aReqReady;
  assign obsImg      = useT ? bImg      : aImg;
  assign obsStart    = useT ? bStart    : aStart;
  assign obsFlush    = useT ? bFlush    : aFlush;
  assign obsRspValid = useT ? bRspValid : aRspValid;
  assign obsRspId    = useT ? bRspId    : aRspId;
  assign obsTo       = useT ? bTo       : aTo;
  assign obsBusy     = useT ? bBusy     : aBusy;
  assign obsCls      = useT ? bCls      : aCls;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pickGrant(input logic [1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkReset();
    checkOutput("rst_req_ready", aReqReady, 0);
    checkOutput("rst_nn_start", aStart, 0);
    checkOutput("rst_nn_flush", aFlush, 0);
    checkOutput("rst_nn_img_sel", aImg, 0);
    checkOutput("rst_rsp_valid", aRspValid, 0);
    checkOutput("rst_rsp_id", aRspId, 0);
    checkOutput("rst_rsp_class", aCls, 0);
    checkOutput("rst_rsp_timeout", aTo, 0);
    checkOutput("rst_busy", aBusy, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    reqValid = '0;
    nnDone = 1'b0;
    rspReady = 1'b0;
    tick();
    tick();
    checkReset();
    rst = 1'b0;
    ptr = 0;
  endtask

  // Runs one job from accept to response handshake on the observed DUT; doneDly < 0 means never.
  task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] imgs, input int dly,
                               input logic [3:0] cls, input int rdyDly, input bit hold,
                               input int expId, input logic [1:0] expImg,
                               input logic [3:0] expCls, input logic expTo);
    int  tlim, decIdx, expDec, flushCnt, flushAt, extraStart;
    bit  got, stable;
    tlim = useT ? T_SHORT : T_LONG;
    expDec = expTo ? tlim - 1 : dly;
    reqImgSel = imgs;
    reqValid = valid;
    nnClass = cls;
    rspReady = 1'b0;
    #1;
    checkOutput("req_ready", obsReqReady, 32'(2'b01 << expId));
    tick();
    if (!hold) reqValid = '0;
    checkOutput("nn_start", obsStart, 1);
    checkOutput("nn_img_sel", obsImg, expImg);
    checkOutput("busy", obsBusy, 1);
    tick();
    rspReady = (rdyDly == 0);
    got = 1'b0;
    flushCnt = 0;
    flushAt = -1;
    extraStart = 0;
    decIdx = -1;
    for (int c = 0; c < tlim + 5 && !got; c++) begin
      nnDone = (dly == c);
      #1;
      if (obsFlush === 1'b1) begin
        flushCnt++;
        flushAt = c;
      end
      if (obsStart !== 1'b0) extraStart++;
      tick();
      nnDone = 1'b0;
      if (obsRspValid === 1'b1) begin
        got = 1'b1;
        decIdx = c;
      end
    end
    checkOutput("rsp_valid_seen", got, 1);
    checkOutput("rsp_latency", decIdx + 3, expDec + 3);
    checkOutput("flush_count", flushCnt, 32'(expTo));
    if (expTo) checkOutput("flush_cycle", flushAt, tlim - 1);
    checkOutput("start_once", extraStart, 0);
    checkOutput("rsp_id", obsRspId, expId);
    checkOutput("rsp_class", obsCls, expCls);
    checkOutput("rsp_timeout", obsTo, expTo);
    stable = 1'b1;
    for (int k = 0; k < rdyDly; k++) begin
      nnDone = (k % 2 == 0);
      tick();
      if (obsRspValid !== 1'b1 || obsRspId !== 1'(expId) || obsCls !== expCls ||
          obsTo !== expTo || obsReqReady !== 2'b00 || obsStart !== 1'b0) stable = 1'b0;
    end
    nnDone = 1'b0;
    if (rdyDly > 0) checkOutput("rsp_stable", stable, 1);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rsp_cleared", obsRspValid, 0);
    checkOutput("idle_busy", obsBusy, 0);
  endtask

  initial begin
    int rspSeen, g, dly, rdy;
    logic [1:0] v;
    logic [3:0] imgs, cls;
    logic to;

    vecs[0] = '{2'b01, 4'b0010, 999, 4'd7, 0, 0, 2'd2, 4'd7, 1'b0};
    vecs[1] = '{2'b11, 4'b1101, 0,   4'd9, 0, 1, 2'd3, 4'd9, 1'b0};
    vecs[2] = '{2'b10, 4'b0100, 5,   4'd0, 2, 1, 2'd1, 4'd0, 1'b0};
    vecs[3] = '{2'b11, 4'b1000, 3,   4'd5, 1, 0, 2'd0, 4'd5, 1'b0};
    vecs[4] = '{2'b01, 4'b0011, 10,  4'd8, 0, 0, 2'd3, 4'd8, 1'b0};

    doReset();
    useT = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].imgs, vecs[i].doneDly, vecs[i].cls, vecs[i].rdyDly,
                    1'b0, vecs[i].expId, vecs[i].expImg, vecs[i].expCls, vecs[i].expTo);
    end

    // Fairness: both requesters keep asking, grants must alternate starting at 0.
    doReset();
    for (int j = 0; j < 6; j++) begin
      applyStimulus(2'b11, 4'b1001, 2 + j, 4'(j), 0, 1'b1, j % 2,
                    (j % 2 == 1) ? 2'd2 : 2'd1, 4'(j), 1'b0);
    end
    reqValid = '0;
    tick();

    // Watchdog abort, then done landing exactly on the timeout cycle.
    doReset();
    useT = 1'b1;
    applyStimulus(2'b01, 4'b0010, -1, 4'd5, 0, 1'b0, 0, 2'd2, 4'hF, 1'b1);
    applyStimulus(2'b10, 4'b1100, T_SHORT - 1, 4'd3, 1, 1'b0, 1, 2'd3, 4'd3, 1'b0);

    // Backpressure with stray done, then an immediate next grant.
    doReset();
    useT = 1'b0;
    applyStimulus(2'b01, 4'b0001, 2, 4'd4, 20, 1'b0, 0, 2'd1, 4'd4, 1'b0);
    applyStimulus(2'b11, 4'b1000, 1, 4'd6, 0, 1'b0, 1, 2'd2, 4'd6, 1'b0);

    // Reset in the middle of WAIT aborts the job with no response.
    doReset();
    reqImgSel = 4'b0011;
    reqValid = 2'b01;
    tick();
    reqValid = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkReset();
    rst = 1'b0;
    rspSeen = 0;
    for (int c = 0; c < 10; c++) begin
      nnDone = (c == 2);
      tick();
      if (aRspValid !== 1'b0) rspSeen++;
    end
    nnDone = 1'b0;
    checkOutput("no_rsp_after_reset", rspSeen, 0);
    checkOutput("idle_after_reset", aBusy, 0);

    // Randomized jobs around the short watchdog limit.
    doReset();
    useT = 1'b1;
    for (int n = 0; n < 16; n++) begin
      v = 2'($urandom_range(1, 3));
      imgs = 4'($urandom);
      cls = 4'($urandom_range(0, 9));
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(44, 56));
      rdy = int'($urandom_range(0, 3));
      g = pickGrant(v, ptr);
      to = (dly < 0) || (dly >= T_SHORT);
      applyStimulus(v, imgs, dly, cls, rdy, 1'b0, g, imgs[g*2 +: 2], to ? 4'hF : cls, to);
      ptr = (g + 1) % NREQ;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL global_time_limit: got expired, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
